inv_shift_rows_stage: RTL and testbench

INV_SHIFT_ROWS_STAGE -- requirements
Module: inv_shift_rows_stage

---
 rtl/inv_shift_rows_stage.sv | 115 +++++++++++
 tb/tb_inv_shift_rows_stage.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/inv_shift_rows_stage.sv
// inv_shift_rows_stage: AES (Inv)ShiftRows byte permutation followed by a
// 2-entry output FIFO with valid/ready handshakes on both sides.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        asynchronous active-high reset
//   state_in   128-bit AES state; byte i = bits [8i+7:8i]
//   mode_in    1 = InvShiftRows (decrypt), 0 = ShiftRows (encrypt)
//   in_valid   producer presents state_in/mode_in
//   in_ready   stage can accept a transaction this cycle (registered)
//   state_out  permuted state of the head entry
//   mode_out   effective mode of the head entry
//   out_valid  head entry is valid
//   out_ready  consumer accepts the head entry
//   xfer_count number of completed output transfers (wraps)
//
// Parameter:
//   INV_ONLY   1 = mode_in ignored, every transaction uses the inverse mapping
module inv_shift_rows_stage #(
  parameter bit INV_ONLY = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] state_in,
  input  logic         mode_in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] state_out,
  output logic         mode_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [15:0]  xfer_count
);

  localparam int unsigned STATE_W = 128;
  localparam int unsigned NBYTES  = 16;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned XFER_W  = 16;
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(2);

  // Column-major AES state: byte m sits at row m%4, column m/4. Row r is
  // rotated left by r columns (forward) or right by r columns (inverse).
  function automatic logic [STATE_W-1:0] permute(input logic [STATE_W-1:0] s,
                                                 input logic inv);
    logic [STATE_W-1:0] r;
    int unsigned row;
    int unsigned col;
    int unsigned src;
    r = '0;
    for (int unsigned m = 0; m < NBYTES; m++) begin
      row = m % 4;
      col = m / 4;
      if (inv) src = row + 4 * ((col + 4 - row) % 4);
      else     src = row + 4 * ((col + row) % 4);
      r[8*m +: 8] = s[8*src +: 8];
    end
    return r;
  endfunction

  logic [STATE_W-1:0] mem_data [0:1];
  logic               mem_mode [0:1];
  logic               rd_ptr;
  logic               wr_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_next;
  logic               eff_mode;
  logic               push;
  logic               pop;

  assign eff_mode  = INV_ONLY ? 1'b1 : mode_in;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_valid = (count != CNT_W'(0));
  assign state_out = mem_data[rd_ptr];
  assign mode_out  = mem_mode[rd_ptr];

  // Occupancy update; simultaneous push and pop leaves count unchanged.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // FIFO storage, pointers, occupancy, ready and transfer counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_data[0] <= '0;
      mem_data[1] <= '0;
      mem_mode[0] <= 1'b0;
      mem_mode[1] <= 1'b0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      count       <= '0;
      in_ready    <= 1'b0;
      xfer_count  <= '0;
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= permute(state_in, eff_mode);
        mem_mode[wr_ptr] <= eff_mode;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr     <= ~rd_ptr;
        xfer_count <= xfer_count + XFER_W'(1);
      end
      count <= count_next;
      // Registered from the next occupancy so ready never depends on out_ready.
      in_ready <= (count_next < DEPTH);
    end
  end

endmodule

// File: tb/tb_inv_shift_rows_stage.sv
// Self-checking bench for inv_shift_rows_stage: reference permutation tables,
// directed vectors, random round trips, backpressure, streaming and reset.
module tb_inv_shift_rows_stage;

  logic         clk;
  logic         rst;
  logic [127:0] state_in;
  logic         mode_in;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_out;
  logic         mode_out;
  logic         out_valid;
  logic         out_ready;
  logic [15:0]  xfer_count;

  logic         in_ready_i;
  logic [127:0] state_out_i;
  logic         mode_out_i;
  logic         out_valid_i;
  logic [15:0]  xfer_count_i;

  int checks = 0;
  int errors = 0;
  int exp_xfer = 0;

  int q_tab [16] = '{0,13,10,7,4,1,14,11,8,5,2,15,12,9,6,3};
  int p_tab [16] = '{0,5,10,15,4,9,14,3,8,13,2,7,12,1,6,11};

  inv_shift_rows_stage #(.INV_ONLY(1'b0)) dut (
    .clk(clk), .rst(rst), .state_in(state_in), .mode_in(mode_in),
    .in_valid(in_valid), .in_ready(in_ready), .state_out(state_out),
    .mode_out(mode_out), .out_valid(out_valid), .out_ready(out_ready),
    .xfer_count(xfer_count)
  );

  inv_shift_rows_stage #(.INV_ONLY(1'b1)) dut_inv (
    .clk(clk), .rst(rst), .state_in(state_in), .mode_in(mode_in),
    .in_valid(in_valid), .in_ready(in_ready_i), .state_out(state_out_i),
    .mode_out(mode_out_i), .out_valid(out_valid_i), .out_ready(out_ready),
    .xfer_count(xfer_count_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] ref_perm(input logic [127:0] s, input logic inv);
    logic [127:0] r;
    r = '0;
    for (int m = 0; m < 16; m++)
      r[8*m +: 8] = inv ? s[8*q_tab[m] +: 8] : s[8*p_tab[m] +: 8];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; state_in = '0; mode_in = 1'b0;
    step(); step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++; if (state_out !== 128'h0) begin errors++; $display("FAIL reset_state_out got %h want 0", state_out); end
    checks++; if (mode_out !== 1'b0) begin errors++; $display("FAIL reset_mode_out got %b want 0", mode_out); end
    checks++; if (xfer_count !== 16'h0) begin errors++; $display("FAIL reset_xfer got %0d want 0", xfer_count); end
    rst = 1'b0;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got %b want 1", in_ready); end
    exp_xfer = 0;
  endtask

  task automatic test_vectors();
    logic [127:0] v;
    v = 128'h0f0e0d0c0b0a09080706050403020100;
    // inverse
    state_in = v; mode_in = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    step(); in_valid = 1'b0;
    checks++; if (state_out !== 128'h0306090c0f0205080b0e0104070a0d00) begin errors++; $display("FAIL vec_inv_state got %h want 0306090c0f0205080b0e0104070a0d00", state_out); end
    checks++; if (mode_out !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL vec_inv_mode got mode=%b valid=%b want 1 1", mode_out, out_valid); end
    step(); exp_xfer++;
    checks++; if (xfer_count !== 16'(exp_xfer)) begin errors++; $display("FAIL vec_inv_xfer got %0d want %0d", xfer_count, exp_xfer); end
    // forward, and the INV_ONLY instance on the same input
    state_in = v; mode_in = 1'b0; in_valid = 1'b1;
    step(); in_valid = 1'b0;
    checks++; if (state_out !== 128'h0b06010c07020d08030e09040f0a0500) begin errors++; $display("FAIL vec_fwd_state got %h want 0b06010c07020d08030e09040f0a0500", state_out); end
    checks++; if (mode_out !== 1'b0) begin errors++; $display("FAIL vec_fwd_mode got %b want 0", mode_out); end
    checks++; if (state_out_i !== 128'h0306090c0f0205080b0e0104070a0d00) begin errors++; $display("FAIL vec_invonly_state got %h want 0306090c0f0205080b0e0104070a0d00", state_out_i); end
    checks++; if (mode_out_i !== 1'b1) begin errors++; $display("FAIL vec_invonly_mode got %b want 1", mode_out_i); end
    step(); exp_xfer++;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL vec_drain got valid=%b want 0", out_valid); end
  endtask

  task automatic test_round_trip();
    logic [127:0] s, f;
    out_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      s = rand128();
      state_in = s; mode_in = 1'b0; in_valid = 1'b1;
      step();
      checks++; if (out_valid !== 1'b1 || state_out !== ref_perm(s, 1'b0)) begin errors++; $display("FAIL rt_fwd[%0d] got %h want %h", i, state_out, ref_perm(s, 1'b0)); end
      f = state_out;
      state_in = f; mode_in = 1'b1;
      step(); in_valid = 1'b0;
      checks++; if (state_out !== s || mode_out !== 1'b1) begin errors++; $display("FAIL rt_back[%0d] got %h want %h", i, state_out, s); end
      step();
      exp_xfer += 2;
    end
    checks++; if (xfer_count !== 16'(exp_xfer)) begin errors++; $display("FAIL rt_xfer got %0d want %0d", xfer_count, exp_xfer); end
  endtask

  task automatic test_backpressure();
    logic [127:0] a, b, c;
    a = rand128(); b = rand128(); c = rand128();
    out_ready = 1'b0; mode_in = 1'b1; in_valid = 1'b1;
    state_in = a; step();
    state_in = b; step();
    state_in = c;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_in_ready got %b want 0", in_ready); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (state_out !== ref_perm(a, 1'b1) || out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold[%0d] got %h want %h", k, state_out, ref_perm(a, 1'b1)); end
      step();
    end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_still_full got %b want 0", in_ready); end
    out_ready = 1'b1;
    step();
    checks++; if (state_out !== ref_perm(b, 1'b1) || in_ready !== 1'b1) begin errors++; $display("FAIL bp_second got %h rdy=%b want %h rdy=1", state_out, in_ready, ref_perm(b, 1'b1)); end
    step(); in_valid = 1'b0;
    checks++; if (state_out !== ref_perm(c, 1'b1) || out_valid !== 1'b1) begin errors++; $display("FAIL bp_third got %h want %h", state_out, ref_perm(c, 1'b1)); end
    step();
    exp_xfer += 3;
    checks++; if (out_valid !== 1'b0 || xfer_count !== 16'(exp_xfer)) begin errors++; $display("FAIL bp_drain got valid=%b xfer=%0d want 0 %0d", out_valid, xfer_count, exp_xfer); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] d;
    logic         md;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      d = rand128(); md = 1'($urandom_range(0, 1));
      state_in = d; mode_in = md; in_valid = 1'b1;
      step();
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b1 || state_out !== ref_perm(d, md) || mode_out !== md) begin
        errors++; $display("FAIL stream[%0d] got %h m=%b rdy=%b want %h m=%b rdy=1", i, state_out, mode_out, in_ready, ref_perm(d, md), md);
      end
    end
    in_valid = 1'b0;
    step();
    exp_xfer += 100;
    checks++; if (out_valid !== 1'b0 || xfer_count !== 16'(exp_xfer)) begin errors++; $display("FAIL stream_xfer got valid=%b xfer=%0d want 0 %0d", out_valid, xfer_count, exp_xfer); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] d;
    out_ready = 1'b0; mode_in = 1'b0; in_valid = 1'b1;
    state_in = rand128(); step();
    state_in = rand128(); step();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || state_out !== 128'h0 || xfer_count !== 16'h0) begin
      errors++; $display("FAIL mid_reset got valid=%b state=%h xfer=%0d want 0 0 0", out_valid, state_out, xfer_count);
    end
    #3 rst = 1'b0;
    exp_xfer = 0;
    step();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_release got rdy=%b valid=%b want 1 0", in_ready, out_valid); end
    d = rand128();
    state_in = d; mode_in = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    step(); in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || state_out !== ref_perm(d, 1'b1)) begin errors++; $display("FAIL mid_reset_push got %h want %h", state_out, ref_perm(d, 1'b1)); end
    step(); exp_xfer++;
    checks++; if (xfer_count !== 16'(exp_xfer)) begin errors++; $display("FAIL mid_reset_xfer got %0d want %0d", xfer_count, exp_xfer); end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_round_trip();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
